ascon_init_ctrl: RTL

- Iterative controller for the ASCON initialization phase.
- Loads the 320-bit state {IV, K, N} and drives an external single-round permutation core for ROUNDS cycles, supplying one round constant per cycle.
- Applies the final key XOR to x3/x4 and presents the initial state for the absorb/encrypt stages.
- Replaces the fully unrolled 12-round permutation with a one-round-per-cycle schedule.

---
 rtl/ascon_init_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ascon_init_ctrl.sv
// ASCON initialization controller: loads {IV, K, N}, steps an external one-round
// permutation core ROUNDS times, then folds the key into x3/x4.
module ascon_init_ctrl #(
    parameter int unsigned ROUNDS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] IV,
    input  logic [63:0] k0,
    input  logic [63:0] k1,
    input  logic [63:0] n0,
    input  logic [63:0] n1,
    output logic [63:0] rnd_x0,
    output logic [63:0] rnd_x1,
    output logic [63:0] rnd_x2,
    output logic [63:0] rnd_x3,
    output logic [63:0] rnd_x4,
    output logic [7:0]  rnd_c,
    input  logic [63:0] rnd_y0,
    input  logic [63:0] rnd_y1,
    input  logic [63:0] rnd_y2,
    input  logic [63:0] rnd_y3,
    input  logic [63:0] rnd_y4,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] RC_OFS   = CNT_W'(12 - ROUNDS);

    if (ROUNDS < 1 || ROUNDS > 12) begin : g_bad_rounds
        $error("ascon_init_ctrl: ROUNDS must be within 1..12");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      x0, x1, x2, x3, x4;
    logic [63:0]      ks0, ks1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rc_idx;

    // Control and datapath share one register process; done defaults low so it pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x0    <= '0;
            x1    <= '0;
            x2    <= '0;
            x3    <= '0;
            x4    <= '0;
            ks0   <= '0;
            ks1   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x0    <= IV;
                        x1    <= k0;
                        x2    <= k1;
                        x3    <= n0;
                        x4    <= n1;
                        ks0   <= k0;
                        ks1   <= k1;
                        cnt   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x0  <= rnd_y0;
                    x1  <= rnd_y1;
                    x2  <= rnd_y2;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        x3    <= rnd_y3 ^ ks0;
                        x4    <= rnd_y4 ^ ks1;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x3 <= rnd_y3;
                        x4 <= rnd_y4;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shorter schedules use the tail of the 12-round constant sequence.
    always_comb begin
        rnd_c  = 8'h00;
        rc_idx = RC_OFS + cnt;
        if (state == RUN) begin
            rnd_c = {4'hF - rc_idx, rc_idx};
        end
    end

    assign rnd_x0 = x0;
    assign rnd_x1 = x1;
    assign rnd_x2 = x2;
    assign rnd_x3 = x3;
    assign rnd_x4 = x4;
    assign y0     = x0;
    assign y1     = x1;
    assign y2     = x2;
    assign y3     = x3;
    assign y4     = x4;

endmodule
